// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants and response tag type for the data RAM arbiter
package dmem_pkg;
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;
  localparam int PRIO_RR = 0;
  localparam int PRIO_FIXED = 1;
  typedef struct packed {
    logic v;
    logic port;
    logic we;
  } rsp_tag_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way arbiter, round-robin or fixed priority, owns the RR pointer
module rr_arb2
  import dmem_pkg::*;
#(
  parameter int PRIO_MODE = PRIO_RR
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);
  logic ptr_q, ptr_d;
  // pick a winner; after any accept the pointer favours the port that lost
  always_comb begin
    gnt = !accept ? 2'b00 : (req == 2'b11) ? ((PRIO_MODE == PRIO_FIXED || ptr_q == PORT_CPU) ? 2'b01 : 2'b10) : req;
    ptr_d = (|gnt) ? gnt[0] : ptr_q;
  end
  // pointer flop, port 0 preferred out of reset
  always_ff @(posedge clk) begin
    ptr_q <= rst ? PORT_CPU : ptr_d;
  end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data RAM between the CPU and the debug loader
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1,
  parameter int PRIO_MODE = PRIO_RR
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req_valid,
  input  logic [1:0]          req_we,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          req_ready,
  output logic [1:0]          rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);
  logic live_q, live_d;
  logic [1:0] gnt;
  logic sel;
  rsp_tag_t tag_q [RD_LAT];
  rsp_tag_t tag_d [RD_LAT];
  rsp_tag_t tag_out;
  rr_arb2 #(.PRIO_MODE(PRIO_MODE)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (req_valid),
    .accept(live_q & ~rst),
    .gnt   (gnt)
  );
  assign req_ready = gnt;
  // command mux to the RAM, tag pipeline advance and response decode at the pipe exit
  always_comb begin
    sel = gnt[PORT_DBG];
    mem_en = |gnt;
    mem_we = mem_en & req_we[sel];
    mem_addr = mem_en ? req_addr[sel*ADDR_W +: ADDR_W] : '0;
    mem_wdata = mem_we ? req_wdata[sel*DATA_W +: DATA_W] : '0;
    tag_d[0] = '{v: mem_en, port: sel, we: mem_we};
    for (int i = 1; i < RD_LAT; i++) tag_d[i] = tag_q[i-1];
    tag_out = tag_q[RD_LAT-1];
    rsp_valid = (tag_out.v & ~rst) ? (2'b01 << tag_out.port) : 2'b00;
    rsp_rdata = (tag_out.v & ~tag_out.we & ~rst) ? mem_rdata : '0;
    live_d = 1'b1;
  end
  // live_q keeps grants off for the first cycle after reset; reset drops in-flight tags
  always_ff @(posedge clk) begin
    if (rst) begin
      live_q <= 1'b0;
      for (int i = 0; i < RD_LAT; i++) tag_q[i] <= '0;
    end else begin
      live_q <= live_d;
      tag_q <= tag_d;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: three arbiter configs (RR lat1, fixed lat1, RR lat3) against a queue-based model
module tb_dmem_arbiter;
  localparam int AW = 6;
  localparam int DW = 32;
  typedef struct {
    int          due;
    logic [1:0]  port;
    logic [31:0] data;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] rv [3];
  logic [1:0] rw [3];
  logic [2*AW-1:0] ra [3];
  logic [2*DW-1:0] rd [3];
  logic [1:0] rdy [3];
  logic [1:0] rspv [3];
  logic [31:0] rspd [3];
  logic men [3];
  logic mwe [3];
  logic [5:0] mad [3];
  logic [31:0] mwd [3];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic pref [3];
  logic live [3];
  logic [31:0] mm [3][64];
  exp_t eq [3][$];
  logic [1:0] lg [3];
  logic pend [3][2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gi
    localparam int LAT = (g == 2) ? 3 : 1;
    logic [31:0] ram [64];
    logic [31:0] pipe [LAT];
    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT), .PRIO_MODE(g == 1 ? 1 : 0)) dut (
      .clk      (clk),
      .rst      (rst),
      .req_valid(rv[g]),
      .req_we   (rw[g]),
      .req_addr (ra[g]),
      .req_wdata(rd[g]),
      .req_ready(rdy[g]),
      .rsp_valid(rspv[g]),
      .rsp_rdata(rspd[g]),
      .mem_en   (men[g]),
      .mem_we   (mwe[g]),
      .mem_addr (mad[g]),
      .mem_wdata(mwd[g]),
      .mem_rdata(pipe[LAT-1])
    );
    initial for (int i = 0; i < 64; i++) ram[i] = 32'h0;
    always @(posedge clk) begin
      for (int i = LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = (men[g] && !mwe[g]) ? ram[mad[g]] : 32'h0;
      if (men[g] && mwe[g]) ram[mad[g]] = mwd[g];
    end
  end

  task automatic chk(string t, int g, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s inst%0d cyc%0d got %h exp %h", t, g, cyc, got, exp);
    end
  endtask

  task automatic drive(logic [1:0] v, logic [1:0] we, logic [5:0] a0, logic [5:0] a1, logic [31:0] d0, logic [31:0] d1);
    for (int g = 0; g < 3; g++) begin
      rv[g] = v;
      rw[g] = we;
      ra[g] = {a1, a0};
      rd[g] = {d1, d0};
    end
  endtask

  // one cycle: predict grant and response from the rules, compare, update model, advance
  task automatic step();
    #1;
    for (int g = 0; g < 3; g++) begin
      logic [1:0] e;
      logic s;
      logic [5:0] a;
      logic [1:0] ev;
      logic [31:0] ed;
      if (rst || !live[g]) e = 2'b00;
      else if (rv[g] == 2'b11) e = (g == 1 || !pref[g]) ? 2'b01 : 2'b10;
      else e = rv[g];
      s = e[1];
      a = ra[g][s*AW +: AW];
      chk("ready", g, {30'b0, rdy[g]}, {30'b0, e});
      chk("mem_en", g, {31'b0, men[g]}, {31'b0, |e});
      chk("mem_addr", g, {26'b0, mad[g]}, (e != 0) ? {26'b0, a} : 32'h0);
      if (e != 0) begin
        chk("mem_we", g, {31'b0, mwe[g]}, {31'b0, rw[g][s]});
        if (rw[g][s]) chk("mem_wdata", g, mwd[g], rd[g][s*DW +: DW]);
      end
      ev = 2'b00;
      ed = 32'h0;
      if (!rst && eq[g].size() > 0 && eq[g][0].due == cyc) begin
        ev = eq[g][0].port;
        ed = eq[g][0].data;
        void'(eq[g].pop_front());
      end
      chk("rsp_valid", g, {30'b0, rspv[g]}, {30'b0, ev});
      chk("rsp_rdata", g, rspd[g], ed);
      if (rst) begin
        eq[g].delete();
        pref[g] = 1'b0;
        live[g] = 1'b0;
      end else begin
        live[g] = 1'b1;
        if (e != 0) begin
          eq[g].push_back('{due: cyc + ((g == 2) ? 3 : 1), port: e, data: rw[g][s] ? 32'h0 : mm[g][a]});
          if (rw[g][s]) mm[g][a] = rd[g][s*DW +: DW];
          pref[g] = e[0];
        end
      end
      lg[g] = e;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    for (int g = 0; g < 3; g++) begin
      pref[g] = 1'b0;
      live[g] = 1'b0;
      lg[g] = 2'b00;
      pend[g][0] = 1'b0;
      pend[g][1] = 1'b0;
      for (int i = 0; i < 64; i++) mm[g][i] = 32'h0;
    end
    drive(2'b11, 2'b00, 6'd0, 6'd0, 32'h0, 32'h0);
    @(negedge clk);
    repeat (3) step();
    rst = 1'b0;
    step();
    drive(2'b00, 2'b00, 6'd0, 6'd0, 32'h0, 32'h0);
    step();
    drive(2'b01, 2'b01, 6'd5, 6'd0, 32'hDEADBEEF, 32'h0);
    step();
    drive(2'b01, 2'b00, 6'd5, 6'd0, 32'h0, 32'h0);
    step();
    drive(2'b00, 2'b00, 6'd0, 6'd0, 32'h0, 32'h0);
    repeat (3) step();
    drive(2'b01, 2'b01, 6'd1, 6'd0, 32'd11, 32'h0);
    step();
    drive(2'b01, 2'b01, 6'd2, 6'd0, 32'd22, 32'h0);
    step();
    drive(2'b11, 2'b00, 6'd1, 6'd2, 32'h0, 32'h0);
    repeat (12) step();
    drive(2'b10, 2'b00, 6'd1, 6'd2, 32'h0, 32'h0);
    repeat (2) step();
    drive(2'b00, 2'b00, 6'd0, 6'd0, 32'h0, 32'h0);
    repeat (3) step();
    drive(2'b10, 2'b00, 6'd0, 6'd2, 32'h0, 32'h0);
    step();
    drive(2'b00, 2'b00, 6'd0, 6'd0, 32'h0, 32'h0);
    repeat (2) step();
    drive(2'b11, 2'b00, 6'd1, 6'd2, 32'h0, 32'h0);
    step();
    drive(2'b00, 2'b00, 6'd0, 6'd0, 32'h0, 32'h0);
    repeat (3) step();
    drive(2'b01, 2'b00, 6'd5, 6'd0, 32'h0, 32'h0);
    repeat (3) step();
    drive(2'b00, 2'b00, 6'd0, 6'd0, 32'h0, 32'h0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (2) step();
    drive(2'b11, 2'b00, 6'd1, 6'd2, 32'h0, 32'h0);
    step();
    drive(2'b00, 2'b00, 6'd0, 6'd0, 32'h0, 32'h0);
    repeat (3) step();
    for (int n = 0; n < 400; n++) begin
      for (int g = 0; g < 3; g++) begin
        for (int p = 0; p < 2; p++) begin
          if (!pend[g][p] && ($urandom % 3) != 0) begin
            pend[g][p] = 1'b1;
            rw[g][p] = 1'($urandom % 2);
            ra[g][p*AW +: AW] = 6'($urandom % 8);
            rd[g][p*DW +: DW] = $urandom;
          end
          rv[g][p] = pend[g][p];
        end
      end
      rst = (($urandom % 100) == 0);
      step();
      for (int g = 0; g < 3; g++)
        for (int p = 0; p < 2; p++)
          if (lg[g][p]) pend[g][p] = 1'b0;
    end
    rst = 1'b0;
    drive(2'b00, 2'b00, 6'd0, 6'd0, 32'h0, 32'h0);
    repeat (4) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
